// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the execute-stage control and the
// iterative divider.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  kill_i;
    logic [DATA_WIDTH-1:0] res_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, op_i, a_i, b_i, kill_i,
        input  res_o, busy_o, done_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, kill_i,
        output res_o, busy_o, done_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for div/divu/rem/remu, one quotient bit
// per cycle, with start/busy/done handshake and a pipeline kill.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic       clk_i,
    input logic       rst_i,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] dvd_q, dvs_q, quo_q, rem_q, res_q;
    logic [CW-1:0]         cnt_q;
    logic                  q_neg_q, r_neg_q;

    logic                  signed_op, div_zero, overflow, special;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, special_res;
    logic [DATA_WIDTH:0]   part_rem;
    logic [DATA_WIDTH-1:0] trial, rem_nxt, quo_nxt, final_res;
    logic                  q_bit;

    // Operand decode at start: magnitudes and the fixed-latency special cases.
    always_comb begin
        signed_op   = ~bus.op_i[0];
        a_mag       = (signed_op && bus.a_i[DATA_WIDTH-1]) ? -bus.a_i : bus.a_i;
        b_mag       = (signed_op && bus.b_i[DATA_WIDTH-1]) ? -bus.b_i : bus.b_i;
        div_zero    = (bus.b_i == '0);
        overflow    = signed_op && (bus.a_i == MIN_NEG) && (bus.b_i == '1);
        special     = div_zero || overflow;
        if (div_zero) special_res = bus.op_i[1] ? bus.a_i : '1;
        else          special_res = bus.op_i[1] ? '0 : bus.a_i;
    end

    // One restoring step; the trial difference is exact in DATA_WIDTH bits
    // whenever it is kept, because the kept remainder is always below |b|.
    always_comb begin
        part_rem = {rem_q, dvd_q[DATA_WIDTH-1]};
        q_bit    = (part_rem >= {1'b0, dvs_q});
        trial    = part_rem[DATA_WIDTH-1:0] - dvs_q;
        rem_nxt  = q_bit ? trial : part_rem[DATA_WIDTH-1:0];
        quo_nxt  = {quo_q[DATA_WIDTH-2:0], q_bit};
        case (op_q)
            OP_DIV:  final_res = q_neg_q ? -quo_nxt : quo_nxt;
            OP_DIVU: final_res = quo_nxt;
            OP_REM:  final_res = r_neg_q ? -rem_nxt : rem_nxt;
            default: final_res = rem_nxt;
        endcase
    end

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = special ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (bus.kill_i) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the datapath registers are all cleared by reset, since res_o is
    // architecturally visible and must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i && !bus.kill_i) begin
                    op_q    <= bus.op_i;
                    dvd_q   <= a_mag;
                    dvs_q   <= b_mag;
                    quo_q   <= '0;
                    rem_q   <= '0;
                    cnt_q   <= CW'(DATA_WIDTH - 1);
                    q_neg_q <= signed_op && (bus.a_i[DATA_WIDTH-1] ^ bus.b_i[DATA_WIDTH-1]);
                    r_neg_q <= signed_op && bus.a_i[DATA_WIDTH-1];
                    if (special) res_q <= special_res;
                end
                RUN: if (!bus.kill_i) begin
                    dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) res_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.res_o  = res_q;
    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = (state_q == DONE);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, randomized operands
// against an arithmetic reference, kill, ignored start, reset and back-to-back.
module tb_div_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    div_unit_if #(.DATA_WIDTH(W)) bus ();
    div_unit #(.DATA_WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, b);
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : MIN_NEG;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [1:0] op, input logic [W-1:0] a, b);
        if (b == '0 || (!op[0] && a == MIN_NEG && b == '1)) return 1;
        return W + 1;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.a_i  = $urandom;
        bus.b_i  = $urandom;
        bus.op_i = 2'($urandom_range(0, 3));
    endtask

    // Called one negedge after the start edge; counts cycles and busy until done.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 1;
        busy_cnt = 0;
        while (bus.done_o !== 1'b1 && cycles < 100) begin
            if (bus.busy_o === 1'b1) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (bus.busy_o === 1'b1) busy_cnt++;
    endtask

    // Must be entered at a negedge with the DUT idle; leaves one idle cycle later.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, b, input logic [W-1:0] exp_res);
        int cycles, busy_cnt, exp_lat;
        exp_lat     = model_latency(op, a, b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        scramble_inputs();
        wait_done(cycles, busy_cnt);
        cmp({name, " latency"}, W'(cycles), W'(exp_lat));
        cmp({name, " busy cycles"}, W'(busy_cnt), W'(exp_lat));
        cmp({name, " result"}, bus.res_o, exp_res);
        last_res = exp_res;
        @(negedge clk);
        cmp({name, " done pulse width"}, W'(bus.done_o), '0);
        cmp({name, " busy after done"}, W'(bus.busy_o), '0);
        cmp({name, " result held"}, bus.res_o, exp_res);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (2) @(negedge clk);
        cmp("reset res", bus.res_o, '0);
        cmp("reset busy", W'(bus.busy_o), '0);
        cmp("reset done", W'(bus.done_o), '0);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2);
        run_op("div -100/7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_op("rem -100/7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        run_op("rem 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2);
        run_op("div by zero", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("rem by zero", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("div overflow", 2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
        run_op("rem overflow", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
        run_op("divu min/-1", 2'b01, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       begin a = MIN_NEG; b = '1; end
                2:       b = W'($urandom_range(1, 15));
                3:       begin a = W'($urandom_range(0, 200)); b = -W'($urandom_range(1, 9)); end
                default: ;
            endcase
            run_op("random", op, a, b, model(op, a, b));
        end
    endtask

    task automatic test_kill();
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'hDEAD_BEEF;
        bus.b_i     = 32'd13;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        cmp("kill busy", W'(bus.busy_o), '0);
        cmp("kill done", W'(bus.done_o), '0);
        cmp("kill res held", bus.res_o, last_res);
        run_op("after kill", 2'b00, 32'hFFFF_0000, 32'd3, model(2'b00, 32'hFFFF_0000, 32'd3));

        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        bus.op_i    = 2'b01;
        bus.b_i     = 32'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        cmp("kill with start busy", W'(bus.busy_o), '0);

        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'h0000_0042;
        bus.b_i     = 32'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b1;
        cmp("kill in done: done", W'(bus.done_o), W'(1));
        @(negedge clk);
        bus.kill_i = 1'b0;
        last_res   = 32'hFFFF_FFFF;
        cmp("kill in done: busy", W'(bus.busy_o), '0);
        cmp("kill in done: res", bus.res_o, last_res);
    endtask

    task automatic test_ignored_start();
        int cycles, busy_cnt;
        logic [W-1:0] a, b, exp_res;
        a = $urandom;
        b = W'($urandom_range(2, 1000));
        exp_res = a / b;
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        cycles   = 1;
        busy_cnt = 0;
        while (bus.done_o !== 1'b1 && cycles < 100) begin
            bus.start_i = (cycles == 4 || cycles == 31);
            if (bus.start_i) scramble_inputs();
            @(negedge clk);
            cycles++;
        end
        bus.start_i = 1'b0;
        cmp("ignored start latency", W'(cycles), W'(W + 1));
        cmp("ignored start result", bus.res_o, exp_res);
        last_res = exp_res;
        @(negedge clk);

        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'd12345;
        bus.b_i     = 32'd11;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp("rst mid-run res", bus.res_o, '0);
        cmp("rst mid-run busy", W'(bus.busy_o), '0);
        cmp("rst mid-run done", W'(bus.done_o), '0);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cycles, busy_cnt;
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'h0BAD_F00D;
        bus.b_i     = 32'd0;
        @(negedge clk);
        cmp("b2b first done", W'(bus.done_o), W'(1));
        cmp("b2b first res", bus.res_o, 32'hFFFF_FFFF);
        bus.op_i = 2'b01;
        bus.a_i  = 32'd100;
        bus.b_i  = 32'd7;
        @(negedge clk);
        cmp("b2b idle bubble", W'(bus.busy_o), '0);
        @(negedge clk);
        bus.start_i = 1'b0;
        scramble_inputs();
        wait_done(cycles, busy_cnt);
        cmp("b2b second latency", W'(cycles), W'(W + 1));
        cmp("b2b second res", bus.res_o, 32'd14);
        last_res = 32'd14;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_ignored_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
